// File: rtl/ax_rr_arbiter_if.sv
// ax_rr_arbiter_if: handshake/bus bundle between the Ax requesters, the
// arbiter and the downstream master Ax channel (AW or AR).
//   req_valid_i / req_data_i / req_ready_o : per-requester Ax handshake
//   ax_valid_o  / ax_data_o  / ax_ready_i  : shared master Ax handshake
// Signal suffixes are from the arbiter's point of view.
// modport slave  : the arbiter
// modport master : the environment (requesters + downstream slave)
interface ax_rr_arbiter_if #(
    parameter int  NUM_REQ      = 4,
    parameter type ax_channel_t = logic
);
    logic        [NUM_REQ-1:0] req_valid_i;
    ax_channel_t [NUM_REQ-1:0] req_data_i;
    logic        [NUM_REQ-1:0] req_ready_o;
    logic                      ax_valid_o;
    ax_channel_t               ax_data_o;
    logic                      ax_ready_i;

    modport slave (
        input  req_valid_i, req_data_i, ax_ready_i,
        output req_ready_o, ax_valid_o, ax_data_o
    );

    modport master (
        output req_valid_i, req_data_i, ax_ready_i,
        input  req_ready_o, ax_valid_o, ax_data_o
    );
endinterface

// File: rtl/ax_rr_arbiter.sv
// ax_rr_arbiter: shares one AXI master Ax channel between NUM_REQ requesters.
// A winner is picked round-robin in IDLE, its beat is registered and held on
// the master channel (HOLD) until ax_ready_i. Outstanding transactions are
// counted against MAX_OUTSTANDING; no grant is issued while the cap is reached.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   bus (slave)        requester handshakes + master Ax handshake
//   rsp_done_i         one transaction completed downstream
//   outstanding_o      issued-but-uncompleted count
//   busy_o             HOLD or outstanding_o != 0
//   err_underflow_o    sticky: rsp_done_i seen with count == 0
// Build option: AX_ARB_FIXED_PRIO_EN selects fixed priority (lowest index).

// Per-requester ready decode.
module ax_rr_arbiter_lane #(
    parameter int IDX   = 0,
    parameter int IDX_W = 2
) (
    input  logic             grant_i,
    input  logic [IDX_W-1:0] win_i,
    output logic             ready_o
);
    assign ready_o = grant_i && (win_i == IDX_W'(IDX));
endmodule

module ax_rr_arbiter #(
    parameter int  NUM_REQ         = 4,
    parameter type ax_channel_t    = logic,
    parameter int  MAX_OUTSTANDING = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    ax_rr_arbiter_if.slave                         bus,
    input  logic                                   rsp_done_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   busy_o,
    output logic                                   err_underflow_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [IDX_W:0]   sum_t;   // one extra bit: ptr + offset < 2*NUM_REQ
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic { IDLE, HOLD } state_e;

    state_e             state_q, state_d;
    idx_t               ptr_q, ptr_d;
    ax_channel_t        ax_data_q, ax_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               found;
    idx_t               win;
    sum_t               idx_s;
    logic               cap_ok, grant, hs;
    logic [NUM_REQ-1:0] ready;

    // Search from the pointer, wrapping; first valid requester wins.
    // In fixed-priority builds the pointer never leaves 0, so the same search
    // degenerates to lowest-index-first.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_s = sum_t'(ptr_q) + sum_t'(k);
            if (idx_s >= sum_t'(NUM_REQ)) idx_s = idx_s - sum_t'(NUM_REQ);
            if (!found && bus.req_valid_i[idx_t'(idx_s)]) begin
                found = 1'b1;
                win   = idx_t'(idx_s);
            end
        end
    end

    assign cap_ok = cnt_q < CNT_W'(MAX_OUTSTANDING);
    // rst_ni gates ready so nothing is acknowledged while reset is applied.
    assign grant  = rst_ni && (state_q == IDLE) && found && cap_ok;
    assign hs     = (state_q == HOLD) && bus.ax_ready_i;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        ax_rr_arbiter_lane #(.IDX(g), .IDX_W(IDX_W)) u_lane (
            .grant_i (grant),
            .win_i   (win),
            .ready_o (ready[g])
        );
    end

    // Next state, pointer and output slice.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ax_data_d = ax_data_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d   = HOLD;
                    ax_data_d = bus.req_data_i[win];
`ifdef AX_ARB_FIXED_PRIO_EN
                    ptr_d     = '0;
`else
                    ptr_d     = (win == idx_t'(NUM_REQ - 1)) ? '0 : win + idx_t'(1);
`endif
                end
            end
            HOLD: begin
                if (bus.ax_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding counter; simultaneous issue and completion cancel out.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (hs && !rsp_done_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!hs && rsp_done_i) begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ax_data_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ax_data_q <= ax_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.ax_valid_o  = (state_q == HOLD);
    assign bus.ax_data_o   = ax_data_q;
    assign outstanding_o   = cnt_q;
    assign busy_o          = (state_q == HOLD) || (cnt_q != '0);
    assign err_underflow_o = err_q;
endmodule

// File: tb/tb_ax_rr_arbiter.sv
// tb_ax_rr_arbiter: per-cycle vector table for ax_rr_arbiter (NUM_REQ=4,
// MAX_OUTSTANDING=2) with a payload scoreboard checked on every Ax handshake,
// followed by a hand-written contention sequence on requesters 0 and 3.
module tb_ax_rr_arbiter;
    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] addr;
    } ax_t;

    localparam int NREQ = 4;
    localparam int MAXO = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rsp_done = 1'b0;
    logic [1:0] outstanding;
    logic       busy, err_uf;

    int passed = 0;
    int total  = 0;

    ax_rr_arbiter_if #(.NUM_REQ(NREQ), .ax_channel_t(ax_t)) bus ();

    ax_rr_arbiter #(.NUM_REQ(NREQ), .ax_channel_t(ax_t), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .bus             (bus.slave),
        .rsp_done_i      (rsp_done),
        .outstanding_o   (outstanding),
        .busy_o          (busy),
        .err_underflow_o (err_uf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic       done;
        logic       chk;
        int         ewin;
        logic       evld;
        int         ecnt;
        logic       eerr;
    } vec_t;

    vec_t tbl[$];
    ax_t  sb[$];

    function automatic ax_t pay(input int i);
        ax_t p;
        p.id   = 8'(i + 1);
        p.addr = 16'(16'h1000 * (i + 1) + 16'h0011 * i);
        return p;
    endfunction

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else passed++;
    endtask

    task automatic add(input logic rst, input logic [3:0] v, input logic rdy, input logic done,
                       input logic chk, input int ewin, input logic evld, input int ecnt,
                       input logic eerr);
        vec_t r;
        r.rst = rst; r.v = v; r.rdy = rdy; r.done = done; r.chk = chk;
        r.ewin = ewin; r.evld = evld; r.ecnt = ecnt; r.eerr = eerr;
`ifdef AX_ARB_FIXED_PRIO_EN
        if (ewin >= 0) r.ewin = lowest(v);
`endif
        tbl.push_back(r);
    endtask

    // Scoreboard: every master handshake must carry the next expected payload.
    always @(negedge clk) begin
        if (rst_n && bus.ax_valid_o && bus.ax_ready_i) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_hs", 32'(bus.ax_data_o), 32'hFFFF_FFFF);
            end else begin
                ax_t e;
                e = sb.pop_front();
                check("sb_hs_data", 32'(bus.ax_data_o), 32'(e));
            end
        end
    end

    initial begin
        int hold_win;
        int exp_seq[4];
        hold_win = 0;
        bus.req_valid_i = '0;
        bus.ax_ready_i  = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_data_i[i] = pay(i);

        //   rst  v    rdy done chk win vld cnt err
        add(0, 4'h0, 0, 0, 0, -1, 0, 0, 0);
        add(1, 4'h0, 0, 0, 1, -1, 0, 0, 0);   // reset state
        // round-robin, all valid
        add(1, 4'hF, 1, 0, 1,  0, 0, 0, 0);
        add(1, 4'hF, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'hF, 1, 1, 1,  1, 0, 1, 0);
        add(1, 4'hF, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'hF, 1, 1, 1,  2, 0, 1, 0);
        add(1, 4'hF, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'hF, 1, 1, 1,  3, 0, 1, 0);
        add(1, 4'hF, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'hF, 1, 1, 1,  0, 0, 1, 0);
        add(1, 4'hF, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'hF, 1, 0, 1,  1, 0, 1, 0);
        add(1, 4'hF, 1, 1, 1, -1, 1, 1, 0);   // handshake + done at count 1
        add(1, 4'h0, 0, 0, 1, -1, 0, 1, 0);
        // underflow
        add(1, 4'h0, 0, 1, 1, -1, 0, 1, 0);
        add(1, 4'h0, 0, 1, 1, -1, 0, 0, 0);   // done at count 0
        add(1, 4'h0, 0, 0, 1, -1, 0, 0, 1);
        add(1, 4'h0, 0, 0, 1, -1, 0, 0, 1);
        // cap: requester 1 only, pointer at 2
        add(1, 4'h2, 1, 0, 1,  1, 0, 0, 1);
        add(1, 4'h2, 1, 0, 1, -1, 1, 0, 1);
        add(1, 4'h2, 1, 0, 1,  1, 0, 1, 1);
        add(1, 4'h2, 1, 0, 1, -1, 1, 1, 1);
        add(1, 4'h2, 1, 0, 1, -1, 0, 2, 1);
        add(1, 4'h2, 1, 0, 1, -1, 0, 2, 1);
        add(1, 4'h2, 1, 1, 1, -1, 0, 2, 1);
        add(1, 4'h2, 1, 0, 1,  1, 0, 1, 1);
        add(1, 4'h2, 1, 0, 1, -1, 1, 1, 1);
        add(1, 4'h2, 1, 1, 1, -1, 0, 2, 1);
        add(1, 4'h0, 0, 1, 1, -1, 0, 1, 1);
        // backpressure on requester 2
        add(1, 4'h4, 0, 0, 1,  2, 0, 0, 1);
        for (int i = 0; i < 10; i++) add(1, 4'h4, 0, 0, 1, -1, 1, 0, 1);
        add(1, 4'h4, 1, 0, 1, -1, 1, 0, 1);
        add(1, 4'h0, 0, 0, 1, -1, 0, 1, 1);
        // wrap from pointer 3, then reset mid-HOLD
        add(1, 4'h1, 1, 0, 1,  0, 0, 1, 1);
        add(1, 4'h1, 0, 0, 1, -1, 1, 1, 1);
        add(0, 4'h1, 0, 0, 1, -1, 1, 1, 1);
        add(1, 4'h0, 0, 0, 1, -1, 0, 0, 0);
        add(1, 4'h9, 1, 0, 1,  0, 0, 0, 0);   // pointer back at 0
        add(1, 4'h9, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'h9, 1, 1, 1,  3, 0, 1, 0);
        add(1, 4'h0, 1, 0, 1, -1, 1, 0, 0);
        add(1, 4'h0, 0, 0, 1, -1, 0, 1, 0);

        foreach (tbl[n]) begin
            vec_t r;
            logic [3:0] erdy;
            r = tbl[n];
            @(posedge clk); #1;
            rst_n = r.rst;
            bus.req_valid_i = r.v;
            bus.ax_ready_i  = r.rdy;
            rsp_done        = r.done;
            if (!r.rst) sb.delete();   // held beat is dropped by reset
            if (r.ewin >= 0) begin
                sb.push_back(pay(r.ewin));
                hold_win = r.ewin;
            end
            #1;
            if (r.chk) begin
                erdy = (r.ewin >= 0) ? 4'(1 << r.ewin) : 4'h0;
                check($sformatf("row%0d_ready", n), 32'(bus.req_ready_o), 32'(erdy));
                check($sformatf("row%0d_valid", n), 32'(bus.ax_valid_o), 32'(r.evld));
                check($sformatf("row%0d_cnt", n), 32'(outstanding), 32'(r.ecnt));
                check($sformatf("row%0d_err", n), 32'(err_uf), 32'(r.eerr));
                check($sformatf("row%0d_busy", n), 32'(busy), 32'(r.evld || r.ecnt != 0));
                if (r.evld)
                    check($sformatf("row%0d_data", n), 32'(bus.ax_data_o), 32'(pay(hold_win)));
            end
        end

        // Contention between requesters 0 and 3; count starts at 1.
`ifdef AX_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
`else
        exp_seq = '{0, 3, 0, 3};
`endif
        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1;
            bus.req_valid_i = 4'h9;
            bus.ax_ready_i  = 1'b1;
            rsp_done        = 1'b1;
            sb.push_back(pay(exp_seq[g]));
            #1;
            check($sformatf("contend%0d_ready", g), 32'(bus.req_ready_o), 32'(1 << exp_seq[g]));
            check($sformatf("contend%0d_cnt", g), 32'(outstanding), 32'd1);
            @(posedge clk); #1;
            rsp_done = 1'b0;
            #1;
            check($sformatf("contend%0d_valid", g), 32'(bus.ax_valid_o), 32'd1);
            check($sformatf("contend%0d_data", g), 32'(bus.ax_data_o), 32'(pay(exp_seq[g])));
        end
        @(posedge clk); #1;
        bus.req_valid_i = '0;
        bus.ax_ready_i  = 1'b0;
        #1;
        check("final_cnt", 32'(outstanding), 32'd1);
        check("final_err", 32'(err_uf), 32'd0);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
